seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Consumes the six BCD digits produced by the stopwatch timer and drives a six-digit common-anode 7-segment display by time-multiplexing. It is the stage directly downstream of the timer. A slot counter rotates through the digits. Digits are snapshotted once per frame so the display never tears mid-frame. Optional leading-zero blanking, decimal-point insertion, and inter-digit blanking suppress ghosting.

Parameters:
DIV, 50000, clock cycles per digit slot (>= BLANK+2)
BLANK, 16, cycles at the start of each slot with all anodes off (>= 1, < DIV)
DP_MASK, 6'b010100, dp lit on the slot whose index bit is 1 (bit5 = d ... bit0 = i)
LZB, 1, leading-zero blanking enable

Ports:
clk  in  1  system clock
hard_reset  in  1  synchronous, active-high reset
en  in  1  display enable
d  in  4  BCD digit, leftmost
e  in  4  BCD digit
f  in  4  BCD digit
g  in  4  BCD digit
h  in  4  BCD digit
i  in  4  BCD digit, rightmost
an  out  6  anode enables, active low; an[5]=d ... an[0]=i
seg  out  7  segments, active low, {g,f,e,d,c,b,a}
dp  out  1  decimal point, active low
frame_start  out  1  one-cycle pulse per frame

Behaviour:
- One clock; hard_reset is synchronous and active-high.
- Reset values: cnt=0, idx=0, shadow digits=0, an=6'b111111, seg=7'b1111111, dp=1, frame_start=0.
- Slot counter cnt runs 0..DIV-1.
  - At cnt==DIV-1: cnt<=0 and idx advances (5 wraps to 0).
  - Otherwise cnt increments.
- Scan order: idx 0..5 = d,e,f,g,h,i.
- Snapshot: on the edge where cnt==0 && idx==0, all six inputs load into shadow registers and frame_start goes high for the following cycle only.
  - This includes the first cycle after reset release.
  - Input changes mid-frame have no effect until the next frame.
- Outputs are registered, one cycle latency from (cnt, idx, shadow). They are computed per edge as follows.
  - cnt<BLANK, or en==0, or the current digit is blanked: an=111111, seg=1111111, dp=1.
  - Otherwise: an = one-hot-low at the current digit; seg = decode(shadow[idx]); dp = ~DP_MASK[5-idx].
- Decode (active low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 1111111 (anode still driven; dp per mask)
- Leading-zero blanking: when LZB=1, digit k (d..h) is blanked if shadow digits d through k are all 0. Digit i is never blanked.
- en low: counters and snapshot keep running; only outputs are forced off. Re-enabling resumes on the next edge with no resync.
- Reset mid-frame: all state returns to reset values on that edge. Scanning restarts at slot d with a fresh snapshot.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use DIV=8, BLANK=2 unless stated; a frame is 48 cycles.
1. Reset: hard_reset=1 for 3 cycles with any inputs -> an=111111, seg=1111111, dp=1, frame_start=0 throughout.
2. Scan order: LZB=0, en=1, d..i=1,2,3,4,5,6.
   - an walks 011111, 101111, ..., 111110, each low for 6 cycles after 2 blank cycles.
   - seg=1111001 during the d slot and 0000010 during the i slot.
   - dp low only in the e and g slots.
   - frame_start pulses every 48 cycles.
3. Snapshot: change d from 1 to 7 while idx==3 -> the d slot still shows 1111001 for the rest of that frame; shows 1111000 from the next frame.
4. LZB=1, digits 0,0,0,5,0,0 -> d, e, f slots dark (an=111111); g shows 0010010; h and i show 1000000. With all digits zero, only the i slot is lit, showing 1000000.
5. Invalid digit: e=4'hB -> e slot an=101111, seg=1111111, dp=0 (mask).
6. Control mid-frame:
   - Drop en mid-slot: next edge all outputs off, cnt keeps counting; raise en and the correct slot resumes.
   - Assert hard_reset at idx==4: next edge gives reset values; after release, frame_start pulses and the d slot is scanned first.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// ---------------
// Time-multiplexed driver for a six-digit common-anode 7-segment display fed
// by the stopwatch timer's six BCD digits.
//
// A slot counter (cnt) runs 0..DIV-1. When it wraps, the digit index (idx)
// advances through d, e, f, g, h, i (idx 0..5). The six input digits are
// copied into shadow registers once per frame, at cnt==0 && idx==0, so the
// display never shows digits from two different timer values in one frame.
// The first BLANK cycles of every slot turn all anodes off. This lets the
// previous digit's segments discharge before the next anode switches on, so
// no ghost image appears.
//
// Ports:
//   clk          system clock
//   hard_reset   synchronous, active-high reset
//   en           display enable; scanning continues while low, outputs dark
//   d..i         BCD digits, d leftmost, i rightmost
//   an[5:0]      anode enables, active low, an[5]=d ... an[0]=i
//   seg[6:0]     segments, active low, {g,f,e,d,c,b,a}
//   dp           decimal point, active low
//   frame_start  one-cycle pulse in the cycle after each snapshot
//
// Every output is registered. Each output is computed from cnt, idx and the
// shadow registers, so no combinational path runs from any input to an output.
module seg_scan_driver #(
  parameter int         DIV     = 50000,
  parameter int         BLANK   = 16,
  parameter logic [5:0] DP_MASK = 6'b010100,
  parameter bit         LZB     = 1'b1
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic       en,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [3:0] f,
  input  logic [3:0] g,
  input  logic [3:0] h,
  input  logic [3:0] i,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0]     cnt;
  logic [2:0]        idx;
  // shadow[0] holds d and shadow[5] holds i, which matches the idx scan order.
  logic [5:0][3:0]   shadow;

  logic              snap;
  logic [3:0]        cur_digit;
  logic [5:0]        zero_prefix;
  logic              digit_blank;
  logic              lit;
  logic [5:0]        an_next;
  logic [6:0]        seg_next;
  logic              dp_next;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;  // non-BCD values show no segments
    endcase
    return s;
  endfunction

  always_comb begin
    snap      = (cnt == '0) && (idx == 3'd0);
    cur_digit = shadow[idx];

    // zero_prefix[k] is set when shadow digits d..k are all zero.
    zero_prefix    = '0;
    zero_prefix[0] = (shadow[0] == 4'd0);
    for (int k = 1; k < 6; k++) begin
      zero_prefix[k] = zero_prefix[k-1] && (shadow[k] == 4'd0);
    end

    // The rightmost digit is always shown, so a zero reading displays "0".
    digit_blank = LZB && (idx != 3'd5) && zero_prefix[idx];
    lit         = en && (cnt >= CNT_BLANK) && !digit_blank;

    an_next  = ~(6'b000001 << (3'd5 - idx));
    seg_next = decode(cur_digit);
    dp_next  = ~DP_MASK[3'd5 - idx];
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      cnt         <= '0;
      idx         <= 3'd0;
      shadow      <= '0;
      an          <= 6'b111111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      frame_start <= snap;
      if (snap) begin
        shadow <= {i, h, g, f, e, d};
      end

      if (lit) begin
        an  <= an_next;
        seg <= seg_next;
        dp  <= dp_next;
      end else begin
        an  <= 6'b111111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with DIV=8 and BLANK=2, which gives a 48-cycle frame.
// Two instances share the stimulus: dut0 has leading-zero blanking off, and
// dut1 has it on.
// The reference model works from the frame position only. It counts edges
// since reset, so the position is n % 48, the slot is pos / 8, and the
// offset within the slot is pos % 8.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       hard_reset;
  logic       en;
  logic [3:0] d, e, f, g, h, i;
  logic [5:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fs0, fs1;

  int tests = 0;
  int fails = 0;

  // Each entry packs one cycle's outputs as {an, seg, dp, frame_start}.
  logic [14:0] exp_q0[$];
  logic [14:0] exp_q1[$];
  logic [14:0] x0, x1;

  logic [5:0] dp_mask = 6'b010100;
  logic [3:0] sh [6];
  int         n = 0;
  int         m_pos;
  int         last_pos = -1;
  bit         started = 1'b0;

  localparam logic [14:0] OFF = {6'b111111, 7'b1111111, 1'b1, 1'b0};

  seg_scan_driver #(.DIV(8), .BLANK(2), .DP_MASK(6'b010100), .LZB(1'b0)) u_dut0 (
    .clk(clk), .hard_reset(hard_reset), .en(en),
    .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
  );

  seg_scan_driver #(.DIV(8), .BLANK(2), .DP_MASK(6'b010100), .LZB(1'b1)) u_dut1 (
    .clk(clk), .hard_reset(hard_reset), .en(en),
    .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [14:0] model_out(input int pos, input bit lzb, input logic en_v);
    int         slot, off;
    bit         zero_run, lit;
    logic       fsb;
    logic [5:0] an_v;
    slot     = pos / 8;
    off      = pos % 8;
    fsb      = (pos == 0);
    zero_run = 1'b1;
    for (int k = 0; k <= slot; k++) if (sh[k] != 4'd0) zero_run = 1'b0;
    lit = (en_v == 1'b1) && (off >= 2) && !(lzb && slot < 5 && zero_run);
    if (!lit) return {6'b111111, 7'b1111111, 1'b1, fsb};
    an_v = 6'b111111;
    an_v[5 - slot] = 1'b0;
    return {an_v, seg_of(sh[slot]), ~dp_mask[5 - slot], fsb};
  endfunction

  always @(posedge clk) begin
    if (hard_reset) begin
      started  = 1'b1;
      n        = 0;
      last_pos = -1;
      for (int k = 0; k < 6; k++) sh[k] = 4'd0;
      exp_q0.push_back(OFF);
      exp_q1.push_back(OFF);
    end else if (started) begin
      m_pos = n % 48;
      exp_q0.push_back(model_out(m_pos, 1'b0, en));
      exp_q1.push_back(model_out(m_pos, 1'b1, en));
      if (m_pos == 0) begin
        sh[0] = d; sh[1] = e; sh[2] = f; sh[3] = g; sh[4] = h; sh[5] = i;
      end
      last_pos = m_pos;
      n++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got an/seg/dp/fs=%b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
      x0 = exp_q0.pop_front();
      x1 = exp_q1.pop_front();
      check("model_dut0", {an0, seg0, dp0, fs0}, x0);
      check("model_dut1", {an1, seg1, dp1, fs1}, x1);
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to the next negedge at which the output for frame position k is
  // visible.
  task automatic goto_pos(input int k);
    int budget;
    budget = 0;
    @(negedge clk);
    while (last_pos != k && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (last_pos != k) begin
      tests++;
      fails++;
      $display("FAIL goto_pos: position %0d not reached, at %0d", k, last_pos);
    end
  endtask

  task automatic set_digits(input logic [3:0] vd, ve, vf, vg, vh, vi);
    d = vd; e = ve; f = vf; g = vg; h = vh; i = vi;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int cyc;
    hard_reset = 1'b1;
    en         = 1'b1;
    set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);

    // Reset holds everything dark.
    repeat (3) begin
      @(negedge clk);
      check("reset_dut0", {an0, seg0, dp0, fs0}, OFF);
      check("reset_dut1", {an1, seg1, dp1, fs1}, OFF);
    end

    // Scan order with digits 1..6.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    hard_reset = 1'b0;
    @(negedge clk);
    check("first_frame_start", {an0, seg0, dp0, fs0}, {6'b111111, 7'b1111111, 1'b1, 1'b1});
    goto_pos(1);
    check("d_blank_phase", {an0, seg0, dp0, fs0}, OFF);
    goto_pos(2);
    check("d_slot", {an0, seg0, dp0, fs0}, {6'b011111, 7'b1111001, 1'b1, 1'b0});
    goto_pos(10);
    check("e_slot_dp", {an0, seg0, dp0, fs0}, {6'b101111, 7'b0100100, 1'b0, 1'b0});
    goto_pos(18);
    check("f_slot", {an0, seg0, dp0, fs0}, {6'b110111, 7'b0110000, 1'b1, 1'b0});
    goto_pos(26);
    check("g_slot_dp", {an0, seg0, dp0, fs0}, {6'b111011, 7'b0011001, 1'b0, 1'b0});
    goto_pos(47);
    check("i_slot", {an0, seg0, dp0, fs0}, {6'b111110, 7'b0000010, 1'b1, 1'b0});

    // frame_start period.
    goto_pos(0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (fs0 !== 1'b1 && cyc < 100);
    check("frame_period", 15'(cyc), 15'd48);

    // A mid-frame input change waits for the next snapshot.
    goto_pos(24);
    d = 4'd7;
    i = 4'd9;
    goto_pos(47);
    check("i_held_mid_frame", {an0, seg0, dp0, fs0}, {6'b111110, 7'b0000010, 1'b1, 1'b0});
    goto_pos(2);
    check("d_new_frame", {an0, seg0, dp0, fs0}, {6'b011111, 7'b1111000, 1'b1, 1'b0});
    goto_pos(47);
    check("i_new_frame", {an0, seg0, dp0, fs0}, {6'b111110, 7'b0010000, 1'b1, 1'b0});

    // Leading-zero blanking with digits 0,0,0,5,0,0.
    set_digits(4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0);
    goto_pos(2);
    check("lzb_d_dark", {an1, seg1, dp1, fs1}, OFF);
    check("nolzb_d_zero", {an0, seg0, dp0, fs0}, {6'b011111, 7'b1000000, 1'b1, 1'b0});
    goto_pos(10);
    check("lzb_e_dark", {an1, seg1, dp1, fs1}, OFF);
    goto_pos(18);
    check("lzb_f_dark", {an1, seg1, dp1, fs1}, OFF);
    goto_pos(26);
    check("lzb_g_five", {an1, seg1, dp1, fs1}, {6'b111011, 7'b0010010, 1'b0, 1'b0});
    goto_pos(34);
    check("lzb_h_zero", {an1, seg1, dp1, fs1}, {6'b111101, 7'b1000000, 1'b1, 1'b0});
    goto_pos(42);
    check("lzb_i_zero", {an1, seg1, dp1, fs1}, {6'b111110, 7'b1000000, 1'b1, 1'b0});

    // All zeros: only the i slot is lit.
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    goto_pos(34);
    goto_pos(26);
    check("allzero_g_dark", {an1, seg1, dp1, fs1}, OFF);
    goto_pos(34);
    check("allzero_h_dark", {an1, seg1, dp1, fs1}, OFF);
    goto_pos(42);
    check("allzero_i_lit", {an1, seg1, dp1, fs1}, {6'b111110, 7'b1000000, 1'b1, 1'b0});

    // Invalid digit on e.
    goto_pos(47);
    set_digits(4'd1, 4'hB, 4'd3, 4'd4, 4'd5, 4'd6);
    goto_pos(10);
    check("invalid_e", {an0, seg0, dp0, fs0}, {6'b101111, 7'b1111111, 1'b0, 1'b0});

    // Drop en mid-slot, then restore it.
    goto_pos(12);
    en = 1'b0;
    @(negedge clk);
    check("en_low_dark", {an0, seg0, dp0, fs0}, OFF);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("en_resume_e", {an0, seg0, dp0, fs0}, {6'b101111, 7'b1111111, 1'b0, 1'b0});
    goto_pos(18);
    check("en_resume_f", {an0, seg0, dp0, fs0}, {6'b110111, 7'b0110000, 1'b1, 1'b0});

    // Reset during the h slot.
    goto_pos(35);
    check("h_before_reset", {an0, seg0, dp0, fs0}, {6'b111101, 7'b0010010, 1'b1, 1'b0});
    hard_reset = 1'b1;
    @(negedge clk);
    check("midframe_reset", {an0, seg0, dp0, fs0}, OFF);
    hard_reset = 1'b0;
    @(negedge clk);
    check("restart_frame_start", {an0, seg0, dp0, fs0}, {6'b111111, 7'b1111111, 1'b1, 1'b1});
    goto_pos(2);
    check("restart_d_slot", {an0, seg0, dp0, fs0}, {6'b011111, 7'b1111001, 1'b1, 1'b0});
    goto_pos(10);
    check("restart_e_slot", {an0, seg0, dp0, fs0}, {6'b101111, 7'b1111111, 1'b0, 1'b0});

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
